output_gain_stage: RTL and testbench
====================================

Name: output_gain_stage

Overview:
Stereo output conditioning stage that sits directly upstream of the DAC serialiser and drives its left/right 16-bit signed sample inputs. Once per audio sample it applies a smoothly ramped master gain (zipper-free, with mute) and saturates the result to 16 bits. It flags clipping per channel with a hold time. All logic runs on clk_12; the sample rate is set by a one-cycle sample_valid strobe.

Parameters:
DATA_W, 16, sample width (signed two's complement)
GAIN_W, 8, gain width; unsigned Q1.7, 128 = unity, 255 = ~1.99x
RAMP_STEP, 1, gain change per accepted sample while ramping
CLIP_HOLD, 4800, output samples a clip flag stays high after the last clipped sample (100 ms at 48 kHz)

Ports:
clk_12  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
sample_valid  in  1  one-cycle strobe: left_in/right_in valid this cycle
left_in  in  DATA_W  left sample, signed
right_in  in  DATA_W  right sample, signed
gain_target  in  GAIN_W  requested gain, unsigned Q1.7
mute  in  1  1 = effective target gain is 0
left_out  out  DATA_W  gained, saturated left sample to DAC; holds between updates
right_out  out  DATA_W  gained, saturated right sample to DAC; holds between updates
out_valid  out  1  one-cycle pulse when left_out/right_out update
clip_l  out  1  left-channel clip indicator (held)
clip_r  out  1  right-channel clip indicator (held)
ramp_busy  out  1  1 while gain_cur != effective target

Behaviour:
- Reset (async, active-high): gain_cur = 0, ramp FSM = IDLE, all pipeline valid bits = 0, left_out = right_out = 0, out_valid = 0, clip_l = clip_r = 0, clip counters = 0, ramp_busy = 0. Reset asserted mid-pipeline discards in-flight samples; no out_valid follows.
- Effective target: tgt = mute ? 0 : gain_target, evaluated combinationally each cycle.
- Ramp FSM, states IDLE / UP / DOWN; it advances only on cycles with sample_valid = 1.
  IDLE: gain_cur == tgt. Go to UP if tgt > gain_cur, to DOWN if tgt < gain_cur.
  UP: gain_cur <= min(gain_cur + RAMP_STEP, tgt). Go to IDLE when the result equals tgt.
  DOWN: gain_cur <= max(gain_cur - RAMP_STEP, tgt). Go to IDLE when the result equals tgt.
  A target change while ramping re-evaluates direction on the next sample_valid; there is never overshoot or wrap-around.
  ramp_busy = (state != IDLE) or (gain_cur != tgt).
- Each sample is multiplied by gain_cur as it was before that sample's ramp update. The first sample after reset therefore uses gain 0.
- Pipeline, fully pipelined; accepts sample_valid every cycle.
  S0: on a rising edge with sample_valid = 1, register left_in, right_in and gain_cur.
  S1: product = sample * {0, gain}, a 25-bit signed result.
  S2: arithmetic shift right by 7 (truncation toward minus infinity), then saturate to [-32768, 32767]. Register left_out/right_out, pulse out_valid.
- Latency: out_valid is high for exactly one cycle, in the cycle following the 3rd rising edge after the edge that sampled sample_valid. Outputs are unchanged on all other cycles.
- Unity gain (128) is exactly transparent. Gain 0 gives exactly 0.
- Clip, per channel, updated on each out_valid:
  if that channel saturated: clip = 1, counter = CLIP_HOLD;
  else if counter > 0: counter - 1, and clip = 0 when the counter reaches 0.
  Counter width is clog2(CLIP_HOLD+1).

Decomposition:
- Package output_stage_pkg holds:
  constants DATA_W, GAIN_W, UNITY_GAIN = 128, SAMPLE_MAX = 32767, SAMPLE_MIN = -32768;
  typedef sample_t (logic signed [15:0]), gain_t (logic [7:0]), ramp_state_t enum {IDLE, UP, DOWN}.
- One sub-module, sat_shift: the S1/S2 multiply, shift and saturate for one channel, plus a clipped flag. It is instantiated twice (left, right).
- The ramp FSM and clip counters live in output_gain_stage.

Test Plan:
- Ramp from reset: reset, gain_target = 128, mute = 0, send 130 samples of 1000/-1000 spaced 256 cycles → outputs are 0, then 7/-8, 15/-16, ..., and sample index 128 onward is exactly 1000/-1000. ramp_busy drops after sample 127 is accepted.
- Latency/hold: gain settled at 128, sample_valid with left = 9, right = 6 → out_valid pulses once, 3 edges later, with 9/6. Outputs hold until the next pulse. Back-to-back strobes give back-to-back pulses.
- Saturation: gain 255, left = 32767, right = -32768 → left_out = 32767, right_out = -32768, clip_l = clip_r = 1. With gain 255, left = 100 → 199, no clip.
- Clip hold (CLIP_HOLD = 4): one clipped sample, then 4 clean samples → clip stays 1 through the 3rd clean out_valid and is 0 after the 4th. A re-clip at the 2nd clean sample reloads the counter to 4.
- Mute and retarget: settled at 128, assert mute → gain falls 1 per sample to 0 over 128 samples. Deassert mute at gain 60 → FSM goes UP from 60 without overshoot. Truncation check: gain 1, left = -1 → -1.
- Reset mid-operation: assert reset 1 cycle after sample_valid → no out_valid, outputs 0, gain_cur 0. After release the ramp restarts from 0.

Source files
------------

// File: rtl/output_stage_pkg.sv
// Shared constants and types for the stereo output gain stage.
// Gains are unsigned Q1.7; samples are signed two's complement.
package output_stage_pkg;

    localparam int DATA_W     = 16;
    localparam int GAIN_W     = 8;
    localparam int UNITY_GAIN = 128;
    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [GAIN_W-1:0]        gain_t;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } ramp_state_t;

endpackage

// File: rtl/output_gain_stage_sat_shift.sv
// One channel of the gain datapath: registered multiply, then registered
// Q1.7 arithmetic shift with saturation to the sample range and a clip flag.
module sat_shift #(
    parameter int DATA_W = output_stage_pkg::DATA_W,
    parameter int GAIN_W = output_stage_pkg::GAIN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] sample,
    input  logic [GAIN_W-1:0]        gain,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] result,
    output logic                     clipped
);
    import output_stage_pkg::*;

    localparam int PW   = DATA_W + GAIN_W + 1;
    localparam int FRAC = GAIN_W - 1;
    localparam logic signed [PW-1:0] SAT_HI = PW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

    logic signed [PW-1:0]     prod_q, prod_d;
    logic signed [PW-1:0]     shifted;
    logic                     v1_q, v1_d;
    logic                     v2_q, v2_d;
    logic signed [DATA_W-1:0] res_q, res_d;
    logic                     clip_q, clip_d;

    always_comb begin
        v1_d   = in_valid;
        prod_d = prod_q;
        if (in_valid) begin
            prod_d = PW'(sample) * PW'($signed({1'b0, gain}));
        end

        // Arithmetic shift truncates toward minus infinity.
        shifted = prod_q >>> FRAC;

        v2_d   = v1_q;
        res_d  = res_q;
        clip_d = clip_q;
        if (v1_q) begin
            if (shifted > SAT_HI) begin
                res_d  = SAT_HI[DATA_W-1:0];
                clip_d = 1'b1;
            end else if (shifted < SAT_LO) begin
                res_d  = SAT_LO[DATA_W-1:0];
                clip_d = 1'b1;
            end else begin
                res_d  = shifted[DATA_W-1:0];
                clip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            res_q  <= '0;
            clip_q <= 1'b0;
        end else begin
            prod_q <= prod_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            res_q  <= res_d;
            clip_q <= clip_d;
        end
    end

    assign out_valid = v2_q;
    assign result    = res_q;
    assign clipped   = clip_q;

endmodule

// File: rtl/output_gain_stage.sv
// Stereo DAC-side output stage: zipper-free ramped master gain with mute,
// 16-bit saturation and per-channel held clip indicators.
module output_gain_stage #(
    parameter int DATA_W    = output_stage_pkg::DATA_W,
    parameter int GAIN_W    = output_stage_pkg::GAIN_W,
    parameter int RAMP_STEP = 1,
    parameter int CLIP_HOLD = 4800
) (
    input  logic                     clk_12,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] left_in,
    input  logic signed [DATA_W-1:0] right_in,
    input  logic [GAIN_W-1:0]        gain_target,
    input  logic                     mute,
    output logic signed [DATA_W-1:0] left_out,
    output logic signed [DATA_W-1:0] right_out,
    output logic                     out_valid,
    output logic                     clip_l,
    output logic                     clip_r,
    output logic                     ramp_busy
);
    import output_stage_pkg::*;

    localparam int CNT_W = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;
    localparam logic [GAIN_W:0]  STEP = (GAIN_W + 1)'(RAMP_STEP);
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(CLIP_HOLD);

    ramp_state_t       state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W-1:0] tgt;
    logic [GAIN_W:0]   gain_up;
    logic [GAIN_W-1:0] gain_gap;

    logic                     s0_valid_q, s0_valid_d;
    logic signed [DATA_W-1:0] s0_left_q, s0_left_d;
    logic signed [DATA_W-1:0] s0_right_q, s0_right_d;
    logic [GAIN_W-1:0]        s0_gain_q, s0_gain_d;

    logic                     l_valid, r_valid;
    logic signed [DATA_W-1:0] l_res, r_res;
    logic                     l_clip, r_clip;

    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] left_out_q, left_out_d;
    logic signed [DATA_W-1:0] right_out_q, right_out_d;
    logic                     clip_l_q, clip_l_d;
    logic                     clip_r_q, clip_r_d;
    logic [CNT_W-1:0]         cnt_l_q, cnt_l_d;
    logic [CNT_W-1:0]         cnt_r_q, cnt_r_d;

    // Direction is re-derived on every accepted sample, so the first step is
    // taken on the same sample that leaves IDLE and a retarget mid-ramp
    // simply reverses or stops without overshoot.
    always_comb begin
        tgt      = mute ? '0 : gain_target;
        gain_up  = {1'b0, gain_q} + STEP;
        gain_gap = gain_q - tgt;
        gain_d   = gain_q;
        state_d  = state_q;
        if (sample_valid) begin
            if (tgt > gain_q) begin
                gain_d  = (gain_up >= {1'b0, tgt}) ? tgt : gain_up[GAIN_W-1:0];
                state_d = (gain_d == tgt) ? IDLE : UP;
            end else if (tgt < gain_q) begin
                gain_d  = ({1'b0, gain_gap} <= STEP) ? tgt : gain_q - STEP[GAIN_W-1:0];
                state_d = (gain_d == tgt) ? IDLE : DOWN;
            end else begin
                state_d = IDLE;
            end
        end
        ramp_busy = (state_q != IDLE) || (gain_q != tgt);
    end

    // Capture stage: each sample travels with the gain in force before its own ramp step.
    always_comb begin
        s0_valid_d = sample_valid;
        s0_left_d  = s0_left_q;
        s0_right_d = s0_right_q;
        s0_gain_d  = s0_gain_q;
        if (sample_valid) begin
            s0_left_d  = left_in;
            s0_right_d = right_in;
            s0_gain_d  = gain_q;
        end
    end

    sat_shift #(
        .DATA_W(DATA_W),
        .GAIN_W(GAIN_W)
    ) u_sat_left (
        .clk      (clk_12),
        .rst      (reset),
        .in_valid (s0_valid_q),
        .sample   (s0_left_q),
        .gain     (s0_gain_q),
        .out_valid(l_valid),
        .result   (l_res),
        .clipped  (l_clip)
    );

    sat_shift #(
        .DATA_W(DATA_W),
        .GAIN_W(GAIN_W)
    ) u_sat_right (
        .clk      (clk_12),
        .rst      (reset),
        .in_valid (s0_valid_q),
        .sample   (s0_right_q),
        .gain     (s0_gain_q),
        .out_valid(r_valid),
        .result   (r_res),
        .clipped  (r_clip)
    );

    always_comb begin
        out_valid_d = l_valid & r_valid;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        clip_l_d    = clip_l_q;
        clip_r_d    = clip_r_q;
        cnt_l_d     = cnt_l_q;
        cnt_r_d     = cnt_r_q;
        if (out_valid_d) begin
            left_out_d  = l_res;
            right_out_d = r_res;

            if (l_clip) begin
                clip_l_d = 1'b1;
                cnt_l_d  = HOLD;
            end else if (cnt_l_q != '0) begin
                cnt_l_d  = cnt_l_q - CNT_W'(1);
                clip_l_d = (cnt_l_d != '0);
            end

            if (r_clip) begin
                clip_r_d = 1'b1;
                cnt_r_d  = HOLD;
            end else if (cnt_r_q != '0) begin
                cnt_r_d  = cnt_r_q - CNT_W'(1);
                clip_r_d = (cnt_r_d != '0);
            end
        end
    end

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gain_q      <= '0;
            s0_valid_q  <= 1'b0;
            s0_left_q   <= '0;
            s0_right_q  <= '0;
            s0_gain_q   <= '0;
            out_valid_q <= 1'b0;
            left_out_q  <= '0;
            right_out_q <= '0;
            clip_l_q    <= 1'b0;
            clip_r_q    <= 1'b0;
            cnt_l_q     <= '0;
            cnt_r_q     <= '0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            s0_valid_q  <= s0_valid_d;
            s0_left_q   <= s0_left_d;
            s0_right_q  <= s0_right_d;
            s0_gain_q   <= s0_gain_d;
            out_valid_q <= out_valid_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            clip_l_q    <= clip_l_d;
            clip_r_q    <= clip_r_d;
            cnt_l_q     <= cnt_l_d;
            cnt_r_q     <= cnt_r_d;
        end
    end

    assign left_out  = left_out_q;
    assign right_out = right_out_q;
    assign out_valid = out_valid_q;
    assign clip_l    = clip_l_q;
    assign clip_r    = clip_r_q;

endmodule

// File: tb/tb_output_gain_stage.sv
// Directed bench for output_gain_stage with a short clip hold of 4 samples.
module tb_output_gain_stage;

    logic               clk_12 = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic signed [15:0] left_in, right_in;
    logic [7:0]         gain_target;
    logic               mute;
    logic signed [15:0] left_out, right_out;
    logic               out_valid, clip_l, clip_r, ramp_busy;

    int errors = 0;
    int checks = 0;

    logic signed [15:0] ol, orr;
    int                 ed;

    always #5 clk_12 = ~clk_12;

    output_gain_stage #(
        .DATA_W   (16),
        .GAIN_W   (8),
        .RAMP_STEP(1),
        .CLIP_HOLD(4)
    ) dut (
        .clk_12      (clk_12),
        .reset       (reset),
        .sample_valid(sample_valid),
        .left_in     (left_in),
        .right_in    (right_in),
        .gain_target (gain_target),
        .mute        (mute),
        .left_out    (left_out),
        .right_out   (right_out),
        .out_valid   (out_valid),
        .clip_l      (clip_l),
        .clip_r      (clip_r),
        .ramp_busy   (ramp_busy)
    );

    // Send one sample and wait (bounded) for its out_valid; ed = edges after capture, -1 on timeout.
    task automatic xfer(input logic signed [15:0] l, input logic signed [15:0] r,
                        output logic signed [15:0] lo, output logic signed [15:0] ro,
                        output int edges);
        @(negedge clk_12);
        left_in = l;
        right_in = r;
        sample_valid = 1'b1;
        @(posedge clk_12);
        #1 sample_valid = 1'b0;
        edges = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_12);
            #1;
            if (out_valid === 1'b1) begin
                edges = i;
                break;
            end
        end
        lo = left_out;
        ro = right_out;
    endtask

    task automatic settle(input int n);
        @(negedge clk_12);
        left_in = '0;
        right_in = '0;
        sample_valid = 1'b1;
        repeat (n) @(posedge clk_12);
        #1 sample_valid = 1'b0;
        repeat (6) @(posedge clk_12);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        sample_valid = 1'b0;
        left_in = '0;
        right_in = '0;
        gain_target = 8'd0;
        mute = 1'b0;
        repeat (3) @(posedge clk_12);
        #1;
        checks++; if (left_out !== 16'sd0 || right_out !== 16'sd0) begin errors++;
            $display("FAIL reset_out got %0d/%0d exp 0/0", left_out, right_out); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (clip_l !== 1'b0 || clip_r !== 1'b0) begin errors++;
            $display("FAIL reset_clip got %b%b exp 00", clip_l, clip_r); end
        checks++; if (ramp_busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %b exp 0", ramp_busy); end
        @(negedge clk_12);
        reset = 1'b0;
        gain_target = 8'd128;
        #1;
        checks++; if (ramp_busy !== 1'b1) begin errors++;
            $display("FAIL busy_after_target got %b exp 1", ramp_busy); end
    endtask

    task automatic test_ramp_from_reset;
        int g, el, er;
        for (int k = 0; k < 130; k++) begin
            g = (k < 128) ? k : 128;
            el = (1000 * g) >>> 7;
            er = (-1000 * g) >>> 7;
            xfer(16'sd1000, -16'sd1000, ol, orr, ed);
            checks++; if (ed !== 3) begin errors++;
                $display("FAIL ramp_latency k=%0d got %0d exp 3", k, ed); end
            checks++; if (ol !== 16'(el) || orr !== 16'(er)) begin errors++;
                $display("FAIL ramp_out k=%0d got %0d/%0d exp %0d/%0d", k, ol, orr, el, er); end
            checks++; if (ramp_busy !== (k < 127)) begin errors++;
                $display("FAIL ramp_busy k=%0d got %b exp %b", k, ramp_busy, (k < 127)); end
        end
        checks++; if (ol !== 16'sd1000 || orr !== -16'sd1000) begin errors++;
            $display("FAIL ramp_unity got %0d/%0d exp 1000/-1000", ol, orr); end
    endtask

    task automatic test_latency_hold;
        xfer(16'sd9, 16'sd6, ol, orr, ed);
        checks++; if (ed !== 3) begin errors++;
            $display("FAIL lat_edges got %0d exp 3", ed); end
        checks++; if (ol !== 16'sd9 || orr !== 16'sd6) begin errors++;
            $display("FAIL lat_out got %0d/%0d exp 9/6", ol, orr); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_12);
            #1;
            checks++; if (out_valid !== 1'b0 || left_out !== 16'sd9 || right_out !== 16'sd6) begin errors++;
                $display("FAIL hold cyc=%0d got v=%b %0d/%0d exp v=0 9/6", i, out_valid, left_out, right_out); end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk_12);
        left_in = 16'sd1; right_in = 16'sd2; sample_valid = 1'b1;
        @(posedge clk_12);
        #1 left_in = 16'sd3; right_in = 16'sd4;
        @(posedge clk_12);
        #1 left_in = 16'sd5; right_in = 16'sd6;
        @(posedge clk_12);
        #1 sample_valid = 1'b0;
        @(posedge clk_12);
        #1;
        checks++; if (out_valid !== 1'b1 || left_out !== 16'sd1 || right_out !== 16'sd2) begin errors++;
            $display("FAIL b2b_0 got v=%b %0d/%0d exp v=1 1/2", out_valid, left_out, right_out); end
        @(posedge clk_12);
        #1;
        checks++; if (out_valid !== 1'b1 || left_out !== 16'sd3 || right_out !== 16'sd4) begin errors++;
            $display("FAIL b2b_1 got v=%b %0d/%0d exp v=1 3/4", out_valid, left_out, right_out); end
        @(posedge clk_12);
        #1;
        checks++; if (out_valid !== 1'b1 || left_out !== 16'sd5 || right_out !== 16'sd6) begin errors++;
            $display("FAIL b2b_2 got v=%b %0d/%0d exp v=1 5/6", out_valid, left_out, right_out); end
        @(posedge clk_12);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_end got v=%b exp 0", out_valid); end
    endtask

    task automatic test_saturation;
        gain_target = 8'd255;
        settle(140);
        checks++; if (ramp_busy !== 1'b0) begin errors++;
            $display("FAIL sat_settle busy got %b exp 0", ramp_busy); end
        xfer(16'sd32767, -16'sd32768, ol, orr, ed);
        checks++; if (ol !== 16'sd32767 || orr !== -16'sd32768) begin errors++;
            $display("FAIL sat_out got %0d/%0d exp 32767/-32768", ol, orr); end
        checks++; if (clip_l !== 1'b1 || clip_r !== 1'b1) begin errors++;
            $display("FAIL sat_clip got %b%b exp 11", clip_l, clip_r); end
        xfer(16'sd100, 16'sd0, ol, orr, ed);
        checks++; if (ol !== 16'sd199 || orr !== 16'sd0) begin errors++;
            $display("FAIL gain255_100 got %0d/%0d exp 199/0", ol, orr); end
    endtask

    task automatic test_clip_hold;
        logic [6:0] lclip, rclip, exp_l, exp_r;
        lclip = 7'b0000101;
        rclip = 7'b0000001;
        exp_l = 7'b0111111;
        exp_r = 7'b0001111;
        for (int i = 0; i < 7; i++) begin
            xfer(lclip[i] ? 16'sd32767 : 16'sd100, rclip[i] ? 16'sd32767 : 16'sd100, ol, orr, ed);
            checks++; if (ol !== (lclip[i] ? 16'sd32767 : 16'sd199)) begin errors++;
                $display("FAIL cliphold_out i=%0d got %0d", i, ol); end
            checks++; if (clip_l !== exp_l[i] || clip_r !== exp_r[i]) begin errors++;
                $display("FAIL cliphold i=%0d got %b%b exp %b%b", i, clip_l, clip_r, exp_l[i], exp_r[i]); end
        end
    endtask

    task automatic test_mute_retarget;
        int e;
        gain_target = 8'd128;
        settle(140);
        mute = 1'b1;
        for (int j = 0; j < 68; j++) begin
            xfer(16'sd128, 16'sd0, ol, orr, ed);
            checks++; if (ol !== 16'(128 - j) || orr !== 16'sd0) begin errors++;
                $display("FAIL mute_fall j=%0d got %0d/%0d exp %0d/0", j, ol, orr, 128 - j); end
        end
        mute = 1'b0;
        for (int i = 0; i < 70; i++) begin
            e = (60 + i < 128) ? 60 + i : 128;
            xfer(16'sd128, 16'sd0, ol, orr, ed);
            checks++; if (ol !== 16'(e)) begin errors++;
                $display("FAIL unmute_rise i=%0d got %0d exp %0d", i, ol, e); end
        end
        checks++; if (ramp_busy !== 1'b0) begin errors++;
            $display("FAIL unmute_busy got %b exp 0", ramp_busy); end
        mute = 1'b1;
        for (int j = 0; j < 130; j++) begin
            e = (128 - j > 0) ? 128 - j : 0;
            xfer(16'sd128, 16'sd0, ol, orr, ed);
            checks++; if (ol !== 16'(e)) begin errors++;
                $display("FAIL mute_full j=%0d got %0d exp %0d", j, ol, e); end
        end
        checks++; if (ramp_busy !== 1'b0) begin errors++;
            $display("FAIL muted_busy got %b exp 0", ramp_busy); end
        xfer(16'sd12345, -16'sd777, ol, orr, ed);
        checks++; if (ol !== 16'sd0 || orr !== 16'sd0) begin errors++;
            $display("FAIL gain0 got %0d/%0d exp 0/0", ol, orr); end
        mute = 1'b0;
        gain_target = 8'd1;
        xfer(16'sd0, 16'sd0, ol, orr, ed);
        xfer(-16'sd1, 16'sd1, ol, orr, ed);
        checks++; if (ol !== -16'sd1 || orr !== 16'sd0) begin errors++;
            $display("FAIL trunc got %0d/%0d exp -1/0", ol, orr); end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk_12);
        left_in = 16'sd500; right_in = 16'sd500; sample_valid = 1'b1;
        @(posedge clk_12);
        #1 sample_valid = 1'b0;
        @(posedge clk_12);
        #1 reset = 1'b1;
        seen = 0;
        repeat (3) begin
            @(posedge clk_12);
            #1;
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (left_out !== 16'sd0 || right_out !== 16'sd0 || clip_l !== 1'b0 || clip_r !== 1'b0) begin errors++;
            $display("FAIL midreset_state got %0d/%0d clip %b%b exp 0/0 00", left_out, right_out, clip_l, clip_r); end
        @(negedge clk_12);
        reset = 1'b0;
        repeat (8) begin
            @(posedge clk_12);
            #1;
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++;
            $display("FAIL midreset_valid got %0d pulses exp 0", seen); end
        gain_target = 8'd128;
        for (int k = 0; k < 3; k++) begin
            xfer(16'sd128, 16'sd0, ol, orr, ed);
            checks++; if (ed !== 3 || ol !== 16'(k)) begin errors++;
                $display("FAIL restart k=%0d got %0d (edges %0d) exp %0d (edges 3)", k, ol, ed, k); end
        end
    endtask

    initial begin
        test_reset;
        test_ramp_from_reset;
        test_latency_hold;
        test_back_to_back;
        test_saturation;
        test_clip_hold;
        test_mute_retarget;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
